sort_frame_collector: RTL and testbench



---
 rtl/sort_frame_collector.sv | 118 +++++++++++
 tb/tb_sort_frame_collector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sort_frame_collector.sv
// sort_frame_collector: packs NUMBER consecutive words from a valid/ready
// word stream into one parallel frame, presented on a second valid/ready
// interface. Optional ordering check enabled by defining ORDER_CHECK_EN.
module sort_frame_collector #(
    parameter int WIDTH  = 8,
    parameter int NUMBER = 16,
    localparam int CNT_W = $clog2(NUMBER)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      valid_a,
    output logic                      ready_a,
    input  logic [WIDTH-1:0]          data_i,
    output logic                      valid_b,
    input  logic                      ready_b,
    output logic [NUMBER*WIDTH-1:0]   data_o,
    output logic [CNT_W:0]            fill_o,
    output logic                      order_err_o
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W:0] LAST_IDX = (CNT_W+1)'(NUMBER - 1);

    state_t                  state_q, state_d;
    logic [CNT_W:0]          fill_q, fill_d;
    logic [NUMBER*WIDTH-1:0] lanes_q, lanes_d;
`ifdef ORDER_CHECK_EN
    logic                    err_q, err_d;
    logic [WIDTH-1:0]        last_q, last_d;
`endif

    // Next-state: flush beats everything but reset; words land in lane fill_q
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        lanes_d = lanes_q;
`ifdef ORDER_CHECK_EN
        err_d   = err_q;
        last_d  = last_q;
`endif
        if (flush_i) begin
            state_d = FILL;
            fill_d  = '0;
`ifdef ORDER_CHECK_EN
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                FILL: begin
                    if (valid_a) begin
                        for (int unsigned k = 0; k < NUMBER; k++) begin
                            if (fill_q == (CNT_W+1)'(k)) begin
                                lanes_d[k*WIDTH +: WIDTH] = data_i;
                            end
                        end
                        fill_d = fill_q + 1'b1;
`ifdef ORDER_CHECK_EN
                        if ((fill_q != '0) && (data_i < last_q)) begin
                            err_d = 1'b1;
                        end
                        last_d = data_i;
`endif
                        if (fill_q == LAST_IDX) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ready_b) begin
                        state_d = FILL;
                        fill_d  = '0;
`ifdef ORDER_CHECK_EN
                        err_d   = 1'b0;
`endif
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            fill_q  <= '0;
            lanes_q <= '0;
`ifdef ORDER_CHECK_EN
            err_q   <= 1'b0;
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            lanes_q <= lanes_d;
`ifdef ORDER_CHECK_EN
            err_q   <= err_d;
            last_q  <= last_d;
`endif
        end
    end

    assign ready_a = (state_q == FILL);
    assign valid_b = (state_q == HOLD);
    assign data_o  = lanes_q;
    assign fill_o  = fill_q;
`ifdef ORDER_CHECK_EN
    assign order_err_o = err_q;
`else
    assign order_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sort_frame_collector.sv
// Testbench for sort_frame_collector: directed and random stimulus checked
// every cycle against a queue-based frame model.
module tb_sort_frame_collector;

    localparam int WIDTH  = 8;
    localparam int NUMBER = 16;
    localparam int CNT_W  = $clog2(NUMBER);

    logic                    clk;
    logic                    rst_n;
    logic                    flush_i;
    logic                    valid_a;
    logic                    ready_a;
    logic [WIDTH-1:0]        data_i;
    logic                    valid_b;
    logic                    ready_b;
    logic [NUMBER*WIDTH-1:0] data_o;
    logic [CNT_W:0]          fill_o;
    logic                    order_err_o;

    sort_frame_collector #(.WIDTH(WIDTH), .NUMBER(NUMBER)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush_i(flush_i),
        .valid_a(valid_a),
        .ready_a(ready_a),
        .data_i(data_i),
        .valid_b(valid_b),
        .ready_b(ready_b),
        .data_o(data_o),
        .fill_o(fill_o),
        .order_err_o(order_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: words of the current frame and whether it is complete
    logic [WIDTH-1:0] m_frame[$];
    bit               m_full;
    int               n_checks;
    int               n_pass;
    int               bubbles;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic exp_err();
        logic e = 1'b0;
`ifdef ORDER_CHECK_EN
        for (int i = 1; i < m_frame.size(); i++)
            if (m_frame[i] < m_frame[i-1]) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [NUMBER*WIDTH-1:0] exp_frame();
        logic [NUMBER*WIDTH-1:0] v = '0;
        for (int i = 0; i < m_frame.size(); i++) v[i*WIDTH +: WIDTH] = m_frame[i];
        return v;
    endfunction

    task automatic compare();
        check("ready_a", 256'(ready_a), 256'(!m_full));
        check("valid_b", 256'(valid_b), 256'(m_full));
        check("fill_o", 256'(fill_o), 256'(m_frame.size()));
        check("order_err", 256'(order_err_o), 256'(exp_err()));
        if (m_full) check("data_o", 256'(data_o), 256'(exp_frame()));
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge
    task automatic step(input logic va, input logic [WIDTH-1:0] d, input logic rb,
                        input logic fl, input logic rn);
        valid_a = va; data_i = d; ready_b = rb; flush_i = fl; rst_n = rn;
        @(posedge clk);
        if (!rn || fl) begin
            m_frame.delete(); m_full = 0;
        end else if (m_full) begin
            if (rb) begin m_frame.delete(); m_full = 0; end
        end else if (va) begin
            m_frame.push_back(d);
            if (m_frame.size() == NUMBER) m_full = 1;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_data", 256'(data_o), 256'(0));
    endtask

    initial begin
        n_checks = 0; n_pass = 0; m_full = 0;
        valid_a = 0; data_i = '0; ready_b = 0; flush_i = 0; rst_n = 0;
        @(negedge clk);

        // 1: ascending frame, full rate, single bubble
        do_reset();
        for (int i = 0; i < NUMBER; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
        bubbles = 0;
        for (int i = 0; i < 4; i++) begin
            if (!ready_a) bubbles++;
            step(1'b1, 8'(100 + i), 1'b1, 1'b0, 1'b1);
        end
        check("bubble_cnt", 256'(bubbles), 256'(1));

        // 2: backpressure for 10 cycles with valid_a held
        for (int i = 0; i < NUMBER - 3; i++) step(1'b1, 8'(20 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i < NUMBER; i++) step(1'b1, 8'(i + 60), 1'b1, 1'b0, 1'b1);
        check("bp_lane0", 256'(data_o[WIDTH-1:0]), 256'(8'h3C));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // 3: random gaps, backpressure, occasional flush/reset
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 80) != 0));

        // 4: flush in FILL then in HOLD
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
        check("flush_fill", 256'(fill_o), 256'(0));
        for (int i = 0; i < NUMBER; i++) step(1'b1, 8'(200 + i), 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check("flush_hold", 256'(valid_b), 256'(0));

        // 5: reset mid-frame
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 9), 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        check("rst_mid_data", 256'(data_o), 256'(0));
        for (int i = 0; i < NUMBER; i++) step(1'b1, 8'(i * 3), 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // 6: ordering violation frame, then ascending frame
        for (int i = 0; i < NUMBER; i++) begin
            logic [WIDTH-1:0] w;
            case (i)
                0: w = 8'd1;  1: w = 8'd2;  2: w = 8'd2;
                3: w = 8'd5;  4: w = 8'd3;  default: w = 8'(i + 10);
            endcase
            step(1'b1, w, 1'b0, 1'b0, 1'b1);
        end
`ifdef ORDER_CHECK_EN
        check("err_set", 256'(order_err_o), 256'(1));
`else
        check("err_off", 256'(order_err_o), 256'(0));
`endif
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < NUMBER; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        check("err_clear", 256'(order_err_o), 256'(0));
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
